shift_exec_stage: RTL and testbench
===================================

SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4, meaning the width of the destination-register tag carried with each operation.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered operations.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an upstream operation is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the stage can accept an operation this cycle.
REQ-007 The block SHALL have port in_data, input, 16 bits: the operand to be shifted.
REQ-008 The block SHALL have port in_amt, input, 4 bits: the shift amount, 0-15.
REQ-009 The block SHALL have port in_mode, input, 2 bits: 00 SLL, 01 SRA, 10 or 11 ROR.
REQ-010 The block SHALL have port in_tag, input, TAG_W bits: the destination tag.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is presented downstream.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port out_data, output, 16 bits: the shifted result.
REQ-014 The block SHALL have port out_tag, output, TAG_W bits: the tag of out_data.
REQ-015 The block SHALL have port out_z, output, 1 bit: the zero flag of out_data (see REQ-030).

Function
REQ-016 The block SHALL accept an operation when in_valid and in_ready are both high at a rising edge; the same rule applies downstream with out_valid and out_ready.
REQ-017 The block SHALL compute the result combinationally from the in_* fields and register it, so latency from acceptance to out_valid is exactly 1 cycle.
REQ-018 SLL SHALL zero-fill, SRA SHALL replicate in_data[15], and ROR SHALL rotate right; an amount of 0 SHALL pass in_data unchanged in every mode.
REQ-019 SRA by 15 SHALL yield 16 copies of in_data[15].
REQ-020 The block SHALL hold results in a 2-entry FIFO skid buffer, with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-021 in_ready SHALL be high exactly when the state is not FULL; it SHALL be registered and SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL be high exactly when the state is not EMPTY; out_data, out_tag and out_z SHALL come from the oldest entry.
REQ-023 Transitions SHALL be: accept only → count+1; pop only → count-1; accept and pop together → count unchanged, with order preserved.
REQ-024 Simultaneous accept and pop in state ONE SHALL present the new entry on the next cycle with no bubble.
REQ-025 Outputs SHALL remain stable while out_valid is high and out_ready is low.
REQ-026 flush SHALL force EMPTY on the next edge, discard any same-cycle accept, and take priority over every other event.
REQ-027 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-028 While rst_n is low, the state SHALL be EMPTY, out_valid 0, in_ready 1, and out_data, out_tag and out_z 0, regardless of clk.
REQ-029 Assertion of rst_n mid-operation SHALL discard all buffered entries immediately; the first acceptance SHALL be possible on the first rising edge after rst_n goes high.

Configuration
REQ-030 With macro SHIFT_EXEC_STAGE_ZFLAG_EN defined, out_z SHALL be 1 exactly when the buffered result equals 16'h0000, and SHALL be stored per entry.
REQ-031 Without SHIFT_EXEC_STAGE_ZFLAG_EN, out_z SHALL be tied to 0 and no flag storage SHALL be built.

Verification
REQ-032 The bench SHALL cover: in_data=16'h8001, amt=1, mode=00 → out_data=16'h0002 one cycle later; with mode=01 → 16'hC000; with mode=10 → 16'hC000.
REQ-033 The bench SHALL cover: in_data=16'h8000, amt=15, mode=01 → 16'hFFFF; in_data=16'h1234, amt=0, any mode → 16'h1234.
REQ-034 The bench SHALL cover: out_ready held 0, three back-to-back ops with tags 1, 2, 3 → in_ready drops after 2 accepts; on release, out_tag sequence is 1, 2, 3 with no loss.
REQ-035 The bench SHALL cover: continuous in_valid and out_ready=1 → one result per cycle, in_ready constantly 1.
REQ-036 The bench SHALL cover: FULL state, then flush pulsed with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed op is never output.
REQ-037 The bench SHALL cover, with ZFLAG_EN: in_data=16'h0001, amt=1, mode=01 → out_data=0, out_z=1; then rst_n pulsed low asynchronously mid-stream → out_valid=0 immediately.

Source files
------------

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: 16-bit SLL/SRA/ROR stage with 1-cycle latency and a 2-entry skid FIFO.
// Define SHIFT_EXEC_STAGE_ZFLAG_EN to store and present a per-entry zero flag on out_z.
module shift_exec_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [3:0]       in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_z
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e           state_q, state_d;
  logic             in_ready_q;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      data_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [31:0]      rot;
  logic [15:0]      sra, res;
  logic             push, pop;
  // Kept as separate statements so the arithmetic shift is not made unsigned by a wider expression.
  always_comb begin
    rot = {in_data, in_data} >> in_amt;
    sra = $signed(in_data) >>> in_amt;
    res = (in_mode == 2'b00) ? (in_data << in_amt) : (in_mode == 2'b01) ? sra : rot[15:0];
  end
  assign push      = in_valid & in_ready_q & ~flush;
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = data_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
      state_d  = (push && !pop) ? ((state_q == EMPTY) ? ONE : FULL) :
                 (pop && !push) ? ((state_q == FULL) ? ONE : EMPTY) : state_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        data_q[wr_ptr_q] <= res;
        tag_q[wr_ptr_q]  <= in_tag;
      end
    end
  end
`ifdef SHIFT_EXEC_STAGE_ZFLAG_EN
  logic z_q [2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q[0] <= 1'b0;
      z_q[1] <= 1'b0;
    end else if (push) begin
      z_q[wr_ptr_q] <= (res == 16'h0000);
    end
  end
  assign out_z = z_q[rd_ptr_q];
`else
  assign out_z = 1'b0;
`endif
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: vector table, directed handshake sequences and random traffic vs a queue model.
module tb_shift_exec_stage;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_amt = '0, in_tag = '0;
  logic [1:0]  in_mode = '0;
  logic        in_ready, out_valid, out_z;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  int checks = 0, errors = 0;

  typedef struct {logic [15:0] d; logic [3:0] t;} ent_t;
  ent_t q[$];
  typedef struct {logic [15:0] d; logic [3:0] a; logic [1:0] m; logic [15:0] e;} vec_t;
  vec_t v[9];

  shift_exec_stage #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_z(out_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] shift_ref(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
    logic [15:0] r = d;
    for (int i = 0; i < a; i++)
      r = (m == 2'b00) ? {r[14:0], 1'b0} : (m == 2'b01) ? {r[15], r[15:1]} : {r[0], r[15:1]};
    return r;
  endfunction

  function automatic logic zexp(input logic [15:0] d);
`ifdef SHIFT_EXEC_STAGE_ZFLAG_EN
    return d == 16'h0000;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    pp  = out_ready && (q.size() > 0);
    if (flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back('{shift_ref(in_data, in_amt, in_mode), in_tag});
    end
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", out_tag, q[0].t);
      chk("out_z", out_z, zexp(q[0].d));
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m, input logic [3:0] t);
    in_valid = 1; in_data = d; in_amt = a; in_mode = m; in_tag = t;
  endtask

  task automatic drain();
    in_valid = 0; flush = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    logic [3:0] got[$];
    int pops;
    v[0] = '{16'h8001, 4'd1, 2'b00, 16'h0002};
    v[1] = '{16'h8001, 4'd1, 2'b01, 16'hC000};
    v[2] = '{16'h8001, 4'd1, 2'b10, 16'hC000};
    v[3] = '{16'h8000, 4'd15, 2'b01, 16'hFFFF};
    v[4] = '{16'h1234, 4'd0, 2'b00, 16'h1234};
    v[5] = '{16'h1234, 4'd0, 2'b01, 16'h1234};
    v[6] = '{16'h1234, 4'd0, 2'b10, 16'h1234};
    v[7] = '{16'h1234, 4'd0, 2'b11, 16'h1234};
    v[8] = '{16'h00F0, 4'd4, 2'b11, 16'h000F};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_z", out_z, 0);
    @(negedge clk); rst_n = 1;

    // vector table: each op appears one cycle after acceptance
    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      drive(v[i].d, v[i].a, v[i].m, 4'(i));
      tick();
      in_valid = 0;
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, v[i].e);
      tick();
    end

    // backpressure: two accepts fill the buffer, order preserved on release
    out_ready = 0;
    drive(16'h0011, 4'd1, 2'b00, 4'd1); tick();
    drive(16'h0022, 4'd2, 2'b01, 4'd2); tick();
    chk("bp_in_ready_low", in_ready, 0);
    drive(16'h0033, 4'd3, 2'b10, 4'd3); tick();
    chk("bp_still_low", in_ready, 0);
    out_ready = 1;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      bit acc;
      if (out_valid) got.push_back(out_tag);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 0;
    end
    chk("bp_count", got.size(), 3);
    for (int i = 0; i < got.size(); i++) chk("bp_tag_order", got[i], i + 1);
    drain();

    // streaming: one result per cycle, never stalls
    pops = 0;
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) pops++;
      drive(16'($urandom), 4'($urandom), 2'($urandom), 4'(i));
      tick();
      chk("stream_in_ready", in_ready, 1);
    end
    chk("stream_pops", pops, 19);
    drain();

    // flush from FULL with a same-cycle op that must never emerge
    out_ready = 0;
    drive(16'h0101, 4'd0, 2'b00, 4'd4); tick();
    drive(16'h0202, 4'd0, 2'b00, 4'd5); tick();
    chk("fl_full", in_ready, 0);
    flush = 1; drive(16'hBEEF, 4'd0, 2'b00, 4'd7); tick();
    flush = 0; in_valid = 0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("fl_never_out", out_valid, 0); end

    // zero result, then asynchronous reset mid-stream
    drive(16'h0001, 4'd1, 2'b01, 4'd9); tick();
    chk("z_data", out_data, 16'h0000);
    chk("z_flag", out_z, zexp(16'h0000));
    out_ready = 0;
    drive(16'h4444, 4'd2, 2'b10, 4'd10); tick();
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_data", out_data, 0);
    in_valid = 0;
    #3 rst_n = 1;
    drive(16'h0F0F, 4'd4, 2'b00, 4'd11); tick();
    chk("post_rst_accept", out_valid, 1);
    drain();

    // random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      in_data = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      in_amt = 4'($urandom); in_mode = 2'($urandom); in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
